// File: rtl/cdu_pkg.sv
// Shared types and constants for the CDU incremental angle receiver.
package cdu_pkg;

    localparam int CTR_W = 15;

    typedef logic [CTR_W-1:0] angle_t;

    localparam angle_t ANGLE_MAX  = 15'h7FFF;
    localparam angle_t ANGLE_ZERO = 15'h0000;

    // Outcome of one counter-service slot.
    typedef enum logic [1:0] {
        SVC_NONE,
        SVC_INC,
        SVC_DEC,
        SVC_CANCEL
    } svc_op_t;

endpackage

// File: rtl/cdu_sync_edge.sv
// Synchronizer chain plus rising-edge detect for one asynchronous CDU pulse line.
// Edges are masked until the chain and the previous-level flop hold only
// post-reset samples. Without this mask, a line that is already high when
// reset is released would look like a fresh edge.
module cdu_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [STAGES-1:0] sync;
    logic              prev;
    logic [STAGES:0]   armed;

    // Shift the line through the synchronizer and keep the last synchronized level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            prev  <= 1'b0;
            armed <= '0;
        end else begin
            sync  <= {sync[STAGES-2:0], din};
            prev  <= sync[STAGES-1];
            armed <= {armed[STAGES-1:0], 1'b1};
        end
    end

    assign rise = sync[STAGES-1] & ~prev & armed[STAGES];

endmodule

// File: rtl/agc_cdu_counter.sv
// AGC-side CDU angle counter: pending +/- pulse counters and per-slot service
// arbitration. The result feeds a 15-bit modulo-2^15 angle register.
module agc_cdu_counter
    import cdu_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PEND_W      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cdu_p,
    input  logic        cdu_m,
    input  logic        slot,
    input  logic        zero,
    output logic [14:0] angle,
    output logic        wrap,
    output logic        drop,
    output logic        pend_nz
);

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    logic              rise_p;
    logic              rise_m;
    logic [PEND_W-1:0] pend_p;
    logic [PEND_W-1:0] pend_m;
    logic [PEND_W-1:0] pend_p_next;
    logic [PEND_W-1:0] pend_m_next;
    angle_t            angle_q;
    angle_t            angle_next;
    logic              wrap_next;
    logic              drop_p;
    logic              drop_m;
    logic              take_p;
    logic              take_m;
    svc_op_t           op;

    cdu_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_p (
        .clk  (clk),
        .rst  (rst),
        .din  (cdu_p),
        .rise (rise_p)
    );

    cdu_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_m (
        .clk  (clk),
        .rst  (rst),
        .din  (cdu_m),
        .rise (rise_m)
    );

    // Pick the slot action, net edges against service, and form the next angle.
    always_comb begin
        op          = SVC_NONE;
        take_p      = 1'b0;
        take_m      = 1'b0;
        pend_p_next = pend_p;
        pend_m_next = pend_m;
        drop_p      = 1'b0;
        drop_m      = 1'b0;
        angle_next  = angle_q;
        wrap_next   = 1'b0;

        if (slot && !zero) begin
            if ((pend_p != '0) && (pend_m != '0)) begin
                op = SVC_CANCEL;
            end else if (pend_p != '0) begin
                op = SVC_INC;
            end else if (pend_m != '0) begin
                op = SVC_DEC;
            end
        end

        take_p = (op == SVC_INC) || (op == SVC_CANCEL);
        take_m = (op == SVC_DEC) || (op == SVC_CANCEL);

        if (rise_p && !take_p) begin
            if (pend_p == PEND_MAX) begin
                drop_p = 1'b1;
            end else begin
                pend_p_next = pend_p + 1'b1;
            end
        end else if (!rise_p && take_p) begin
            pend_p_next = pend_p - 1'b1;
        end

        if (rise_m && !take_m) begin
            if (pend_m == PEND_MAX) begin
                drop_m = 1'b1;
            end else begin
                pend_m_next = pend_m + 1'b1;
            end
        end else if (!rise_m && take_m) begin
            pend_m_next = pend_m - 1'b1;
        end

        case (op)
            SVC_INC: begin
                angle_next = angle_q + 1'b1;
                wrap_next  = (angle_q == ANGLE_MAX);
            end
            SVC_DEC: begin
                angle_next = angle_q - 1'b1;
                wrap_next  = (angle_q == ANGLE_ZERO);
            end
            default: begin
                angle_next = angle_q;
                wrap_next  = 1'b0;
            end
        endcase

        if (zero) begin
            pend_p_next = '0;
            pend_m_next = '0;
            angle_next  = ANGLE_ZERO;
            wrap_next   = 1'b0;
            drop_p      = 1'b0;
            drop_m      = 1'b0;
        end
    end

    // Register the counters and the one-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_p  <= '0;
            pend_m  <= '0;
            angle_q <= ANGLE_ZERO;
            wrap    <= 1'b0;
            drop    <= 1'b0;
            pend_nz <= 1'b0;
        end else begin
            pend_p  <= pend_p_next;
            pend_m  <= pend_m_next;
            angle_q <= angle_next;
            wrap    <= wrap_next;
            drop    <= drop_p | drop_m;
            pend_nz <= (pend_p_next != '0) || (pend_m_next != '0);
        end
    end

    assign angle = angle_q;

endmodule

// File: doc/agc_cdu_counter.md
# agc_cdu_counter

AGC-side receiver for the CDU incremental angle interface. It accepts the asynchronous +Δθ/−Δθ pulse lines that the CDU drives toward the AGC and accumulates them into a 15-bit two's-complement angle counter, one count per counter-service slot. It sits opposite the CDU's pulse transmitter and gives the AGC model and the benches a cycle-exact read of the accumulated angle.

## Interface
- SYNC_STAGES, 2, number of synchronizer flops per pulse line (minimum 2)
- PEND_W, 3, width of each pending-pulse counter; depth is 2^PEND_W−1

- clk  in  1  system clock (any rate ≥ 4× the fastest pulse rate)
- rst  in  1  asynchronous, active-high reset; single clock domain on clk
- cdu_p  in  1  +Δθ pulse line from the CDU (asynchronous; each rising edge is one count)
- cdu_m  in  1  −Δθ pulse line from the CDU (asynchronous; each rising edge is one count)
- slot  in  1  counter-service strobe, one cycle wide (AGC counter cycle)
- zero  in  1  synchronous clear of the counter and all pending pulses
- angle  out  15  accumulated angle, two's complement, LSB = 360°/2^15
- wrap  out  1  one-cycle pulse when the count crosses the 0x7FFF↔0x0000 boundary in either direction
- drop  out  1  one-cycle pulse when an edge is lost because its pending counter is saturated
- pend_nz  out  1  high while either pending counter is nonzero

## Operation
- Each line passes through a SYNC_STAGES flop chain, then a rising-edge detect: edge = s[last] & ~s_prev. The edge signal is combinational from registers.
- Pending counters pend_p and pend_m each increment on their edge. If the counter is at its maximum, it holds that value and drop pulses.
- Service happens on a cycle where slot=1 and zero=0:
  - If pend_p>0 and pend_m>0: decrement both; angle unchanged (cancellation, no wrap).
  - Else if pend_p>0: angle+1, pend_p−1.
  - Else if pend_m>0: angle−1, pend_m−1.
  - Else: no change.
- At most one net count is applied per slot.
- Edge and service in the same cycle on the same counter: the pending value is unchanged (+1−1).
  - Saturation is judged after this netting, so a full counter with a simultaneous service does not drop.
- Wrap rules:
  - 0x7FFF+1 → 0x0000 pulses wrap.
  - 0x0000−1 → 0x7FFF pulses wrap.
  - The 15-bit value is treated as an angle modulo 2^15; no other overflow is flagged.
- zero has priority over slot and over edges in the same cycle. It clears angle, pend_p and pend_m, and suppresses wrap and drop that cycle.
  - Edges detected in the zero cycle are discarded.
  - Synchronizer state is not cleared.

## Timing
- Reset values: angle=0, wrap=0, drop=0, pend_nz=0, all synchronizer and pending flops 0.
- Deasserting rst mid-operation resumes cleanly.
- A level already high on cdu_p/cdu_m at reset release does not produce a count; an edge is required.
- Latency, for SYNC_STAGES=2 with slot held high:
  - Input rises before clock edge k.
  - Edge is detected in the cycle after k+1.
  - pend updates at k+2.
  - angle updates at k+3, i.e. SYNC_STAGES+1 edges after first sample.
- wrap and drop are registered and assert in the cycle after the causing edge.
- pend_nz is registered from pend_p and pend_m.
- Minimum input pulse high and low time: 2 clk cycles each. Shorter pulses may be lost; this is not flagged.
- Throughput: one count per slot. Sustained input rate above the slot rate fills the pending counters, then drop pulses.

## Structure
- Shared package cdu_pkg holds:
  - CTR_W = 15 and typedef angle_t (logic [14:0])
  - constants ANGLE_MAX = 15'h7FFF and ANGLE_ZERO = 15'h0000
- One sub-module, cdu_sync_edge (parameter STAGES), instantiated twice. It contains the synchronizer chain plus the rising-edge detect and outputs a one-cycle edge.
- Top level holds the pending counters, the service arbitration and the angle register. Target size is roughly 150–250 lines of RTL.

## Test plan
- Reset/latency: release rst, slot=1 every cycle, one 4-cycle pulse on cdu_p → angle 0→1 exactly 3 clocks after the first sampling edge; pend_nz high for 1 cycle; wrap=drop=0.
- Cancellation: slot held low; pulse cdu_p and cdu_m once each; then single slot → angle stays 0, pend_nz drops to 0, no wrap.
- Wrap both ways:
  - Preload via 0x7FFF counted pulses (or force), then one cdu_p → angle=0x0000, wrap pulses once.
  - Then two cdu_m → 0x7FFF then 0x7FFE, one wrap pulse on the first.
- Saturation: slot low, 9 cdu_p pulses with PEND_W=3 → pend_p=7, drop pulses twice; then 10 slots → angle=7, pend_nz=0.
- Simultaneous events: cdu_p edge detected in the same cycle as a slot with pend_p=7 → pend_p stays 7, angle+1, no drop. zero asserted with slot and edge → angle=0, pending=0, wrap=drop=0.
- Async reset mid-stream: assert rst while pend_p=3 and angle=0x0123 → all outputs 0 immediately (before the next clk edge); after release a high-held cdu_p produces no count.
